// File: rtl/pp_chunk_credit_arb_pkg.sv
// Shared types and constants for the path-parser packet arbiter.
// Source indices identify which header engine a request/grant bit belongs to.
package pp_chunk_credit_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } pp_arb_state_e;

    localparam int unsigned PP_ARB_LH_IDX    = 0;
    localparam int unsigned PP_ARB_ECDSA_IDX = 1;

endpackage

// File: rtl/pp_chunk_credit_arb_fifo.sv
// Small synchronous FIFO with show-ahead output; holds the lengths reserved at grant time
// so the oldest one can be returned when its hop completes.
module sfifo2f_fo #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH_NBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned Depth = 1 << DEPTH_NBITS;

    logic [WIDTH-1:0]       mem_q [Depth];
    logic [DEPTH_NBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_NBITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_NBITS:0]   cnt_q, cnt_d;
    logic                   do_wr, do_rd;

    always_comb begin
        full     = (cnt_q == (DEPTH_NBITS + 1)'(Depth));
        empty    = (cnt_q == '0);
        do_wr    = wr && !full;
        do_rd    = rd && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        dout = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pp_chunk_credit_arb.sv
// Packet-level round-robin arbiter in front of the path parser. Grants a whole packet only when
// the buffer FIFO has credit for it, and owns the buffer-FIFO credit counter.
module pp_chunk_credit_arb
    import pp_chunk_credit_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LEN_NBITS    = 8,
    parameter int unsigned CREDIT_NBITS = 6,
    parameter int unsigned PEND_NBITS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*LEN_NBITS-1:0]   req_len,
    input  logic                           beat_valid,
    input  logic                           beat_eop,
    input  logic                           hop_valid,
    input  logic                           hop_eop,
    input  logic                           buf_fifo_rd,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           gnt_discard,
    output logic [CREDIT_NBITS:0]          credit_cnt,
    output logic                           pend_full
);

    localparam int unsigned MaxCredit = 1 << CREDIT_NBITS;
    localparam int unsigned IdxW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW        = CREDIT_NBITS + 2;

    localparam logic [CREDIT_NBITS:0] MaxCreditC = (CREDIT_NBITS + 1)'(MaxCredit);
    localparam logic signed [CW-1:0]  MaxCreditS = CW'(MaxCredit);

    // Returns {found, index} of the first eligible requester at or after ptr.
    function automatic logic [IdxW:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [IdxW-1:0]    ptr);
        logic [IdxW:0] res;
        int unsigned   idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!res[IdxW] && elig[idx]) begin
                res = {1'b1, IdxW'(idx)};
            end
        end
        return res;
    endfunction

    pp_arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  disc_q, disc_d;
    logic [IdxW-1:0]       win_q, win_d;
    logic [IdxW-1:0]       rr_q, rr_d;
    logic [CREDIT_NBITS:0] credit_q, credit_d;
    logic                  buf_rd_q;

    logic [LEN_NBITS-1:0]  lens [NUM_REQ];
    logic [NUM_REQ-1:0]    oversized;
    logic [NUM_REQ-1:0]    elig;
    logic [IdxW:0]         pick;
    logic                  push;
    logic [LEN_NBITS-1:0]  grant_len;
    logic                  pop;
    logic [LEN_NBITS-1:0]  pop_head;
    logic                  fifo_empty;

    logic signed [CW-1:0]  sum;
    logic                  credit_oob;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            lens[i]      = req_len[i*LEN_NBITS +: LEN_NBITS];
            oversized[i] = 32'(lens[i]) > MaxCredit;
            elig[i]      = req_valid[i] &&
                           (((32'(lens[i]) <= 32'(credit_q)) && !pend_full) || oversized[i]);
        end
        pick = rr_pick(elig, rr_q);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        disc_d    = disc_q;
        win_d     = win_q;
        rr_d      = rr_q;
        push      = 1'b0;
        grant_len = '0;
        unique case (state_q)
            IDLE: begin
                if (pick[IdxW]) begin
                    win_d   = pick[IdxW-1:0];
                    gnt_d   = NUM_REQ'(1) << pick[IdxW-1:0];
                    disc_d  = oversized[pick[IdxW-1:0]];
                    state_d = GRANT;
                    if (!oversized[pick[IdxW-1:0]]) begin
                        push      = 1'b1;
                        grant_len = lens[pick[IdxW-1:0]];
                    end
                end
            end
            GRANT: begin
                if (beat_valid && beat_eop) begin
                    gnt_d   = '0;
                    disc_d  = 1'b0;
                    rr_d    = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sfifo2f_fo #(
        .WIDTH       (LEN_NBITS),
        .DEPTH_NBITS (PEND_NBITS)
    ) u_pend_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (grant_len),
        .wr    (push),
        .rd    (pop),
        .dout  (pop_head),
        .full  (pend_full),
        .empty (fifo_empty)
    );

    // All four credit terms apply in the same cycle with no priority between them.
    always_comb begin
        logic signed [CW-1:0] cur_t, grant_t, hop_t, pop_t, buf_t;
        pop     = hop_valid && hop_eop;
        cur_t   = CW'(credit_q);
        grant_t = CW'(grant_len);
        hop_t   = CW'(hop_valid);
        pop_t   = (pop && !fifo_empty) ? CW'(pop_head) : '0;
        buf_t   = CW'(buf_rd_q);
        sum     = cur_t - grant_t - hop_t + pop_t + buf_t;
        credit_oob = 1'b0;
        if (sum[CW-1]) begin
            credit_d   = '0;
            credit_oob = 1'b1;
        end else if (sum > MaxCreditS) begin
            credit_d   = MaxCreditC;
            credit_oob = 1'b1;
        end else begin
            credit_d = sum[CREDIT_NBITS:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            disc_q   <= 1'b0;
            win_q    <= '0;
            rr_q     <= '0;
            credit_q <= MaxCreditC;
            buf_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            disc_q   <= disc_d;
            win_q    <= win_d;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            buf_rd_q <= buf_fifo_rd;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_discard = disc_q;
    assign credit_cnt  = credit_q;

    a_credit_in_range: assert property (@(posedge clk) disable iff (!rst_n) !credit_oob);
    a_pop_not_empty:   assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));
    a_push_not_full:   assert property (@(posedge clk) disable iff (!rst_n) !(push && pend_full));

endmodule
